uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx byte transmitter among N_REQ byte-stream requesters, e.g. the rx echo path, a status reporter and a debug dumper.
- Uses round-robin arbitration with packet lock: a grant is held from the first byte to the byte flagged last, so messages never interleave on the serial line.
- Its master side drives uart_tx axis_tdata/axis_tvalid and receives axis_tready.
- A stall timeout releases a requester that goes silent mid-packet.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- DATA_W, 8, byte width.
- TIMEOUT_CYC, 1048576, idle cycles allowed mid-packet before forced release (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- s_tdata  in  N_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
- s_tvalid  in  N_REQ  requester byte valid
- s_tlast  in  N_REQ  requester byte is the last of its message
- s_tready  out  N_REQ  requester byte accepted
- m_tdata  out  DATA_W  byte to uart_tx axis_tdata
- m_tvalid  out  1  to uart_tx axis_tvalid
- m_tready  in  1  from uart_tx axis_tready
- grant_id  out  3  index of the current owner; valid while busy
- busy  out  1  a grant is held
- timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset values (synchronous, rst=1 at a clk edge):
  - m_tvalid=0, m_tdata=0, s_tready=0, busy=0, grant_id=0, timeout=0.
  - last_grant=N_REQ-1, so requester 0 wins first.
  - Timeout counter=0. FSM=IDLE.
  - Any byte held in the output register is discarded.
- FSM states: IDLE, GRANT.
- IDLE:
  - s_tready=0.
  - If any s_tvalid is high, pick the first set index scanning last_grant+1, last_grant+2, … modulo N_REQ.
  - Register it as grant_id, set busy=1, go to GRANT. Arbitration costs one cycle.
- GRANT:
  - s_tready[grant_id] = (!m_tvalid || m_tready). All other s_tready bits are 0.
- Transfer:
  - A transfer occurs when s_tvalid[g] && s_tready[g].
  - On transfer, m_tdata<=s_tdata[g] and m_tvalid<=1.
  - Otherwise, if m_tready, then m_tvalid<=0.
  - m_tvalid/m_tdata stay stable while m_tvalid && !m_tready (AXI-stream rule).
  - One registered output stage gives full throughput; the uart_tx rate limits the flow anyway.
- Latency: s_tvalid rises in IDLE at cycle 0 → busy/grant at cycle 1 → s_tready high at cycle 1 (output empty) → m_tvalid at cycle 2.
- Packet end:
  - A transfer with s_tlast[g]=1 → next state IDLE, last_grant<=g, busy<=0.
  - The last byte still drains from the output register normally.
  - Re-arbitration happens from IDLE on the following cycle: one bubble cycle between packets, required.
- Timeout:
  - The counter clears on each transfer and on entering GRANT.
  - It increments each GRANT cycle while s_tvalid[g]=0.
  - Back-pressure (s_tvalid[g]=1, output full) does not count.
  - At count==TIMEOUT_CYC-1: go to IDLE, last_grant<=g, pulse timeout for 1 cycle.
  - No byte is injected on timeout; a partial message is accepted as the line result.
- Fairness: after a release, the releasing requester has the lowest priority.
- Requesters are never starved: each waits at most N_REQ-1 packets (or timeouts).
- Deasserting s_tvalid before tready while in IDLE is tolerated (no grant taken if no valid at the IDLE sample). A grant taken by a requester that then drops valid resolves only via timeout.
- Simultaneous events:
  - tlast transfer and m_tready in the same cycle: both apply; the output keeps the new byte.
  - rst overrides everything.
- Widths: grant_id zero-extended to 3 bits. The counter is clog2(TIMEOUT_CYC) bits and never wraps.

Decomposition:
- Shared package (uart_pkg): UART_DATA_W=8, FSM state enum {IDLE, GRANT}, function rr_pick(req, last) returning the next index.
- One natural sub-module: rr_priority_sel (combinational rotate/priority-encode/rotate-back, parameterised by N_REQ), reusable for other shared resources.
- FSM, timeout counter and output register stay in uart_tx_arbiter.

Test Plan:
1. Reset, then requester 0 sends 0x41,0x42(last) with m_tready=1 → busy at cycle 1; m_tdata 0x41 then 0x42; busy=0 after the last transfer; last_grant=0.
2. All 3 requesters hold 2-byte packets ({0xA0,0xA1},{0xB0,0xB1},{0xC0,0xC1}) → output order A0 A1 B0 B1 C0 C1. Repeat → again A,B,C order; never interleaved.
3. Requester 1 streaming with m_tready toggling 1-in-4 (uart_tx-like) → no byte lost or duplicated; m_tdata stable while m_tvalid && !m_tready.
4. TIMEOUT_CYC=16: requester 2 sends 0x10 without last then drops valid; requester 0 waiting → timeout pulses exactly 16 cycles after the 0x10 transfer; grant moves to 0 next arbitration.
5. Back-pressure with m_tready=0 for 100 cycles, TIMEOUT_CYC=16, requester valid held → no timeout; bytes resume when m_tready=1.
6. rst asserted mid-packet with m_tvalid=1 → next cycle m_tvalid=0, busy=0; after release requester 0 is granted first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx requester arbiter: byte width, FSM states
// and the round-robin pick helper.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

  // Rotate so index last+1 sits at bit 0, take the lowest set bit, rotate back.
  // Returns last when nothing is requested; callers qualify with |req.
  function automatic logic [2:0] rr_pick(input logic [7:0]  req,
                                         input logic [2:0]  last,
                                         input int unsigned n);
    logic [7:0]  rot;
    int unsigned idx;
    int unsigned j;
    logic [2:0]  pick;
    rot  = '0;
    pick = last;
    for (int unsigned i = 0; i < n; i++) begin
      idx            = (32'(last) + 1 + i) % n;
      rot[i[2:0]]    = req[idx[2:0]];
    end
    for (int unsigned i = n; i > 0; i--) begin
      j = i - 1;
      if (rot[j[2:0]]) begin
        idx  = (32'(last) + i) % n;
        pick = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin selector: lowest priority goes to the last winner.
module rr_priority_sel
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [2:0]       last_i,
  output logic [2:0]       pick_o,
  output logic             any_o
);

  logic [7:0] req_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req_i;
  end

  assign pick_o = rr_pick(req_ext, last_i, N_REQ);
  assign any_o  = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx byte port among
// N_REQ AXI-stream requesters, with a mid-packet stall timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned DATA_W      = UART_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] s_tdata,
  input  logic [N_REQ-1:0]        s_tvalid,
  input  logic [N_REQ-1:0]        s_tlast,
  output logic [N_REQ-1:0]        s_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    timeout
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]       LAST_RST = 3'(N_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [2:0]         grant_q, grant_d;
  logic [2:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0]  m_tdata_q, m_tdata_d;
  logic               timeout_q, timeout_d;

  logic [2:0]         pick;
  logic               any_req;
  logic               sel_valid, sel_last;
  logic [DATA_W-1:0]  sel_data;
  logic               out_ready, xfer, stall_to;

  rr_priority_sel #(.N_REQ(N_REQ)) u_sel (
    .req_i  (s_tvalid),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (any_req)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
        sel_data  = s_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign out_ready = !m_tvalid_q || m_tready;
  assign xfer      = (state_q == GRANT) && sel_valid && out_ready;
  // Only silence counts toward release; a back-pressured requester is not stalled.
  assign stall_to  = (state_q == GRANT) && !sel_valid && (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          grant_d = pick;
        end
      end
      GRANT: begin
        if ((xfer && sel_last) || stall_to) begin
          state_d   = IDLE;
          last_d    = grant_q;
          timeout_d = stall_to;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == GRANT);
    s_tready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (busy && (grant_q == 3'(i))) s_tready[i] = out_ready;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    if ((state_q == IDLE) || xfer)             cnt_d = '0;
    else if (!sel_valid && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    if (xfer) begin
      m_tdata_d  = sel_data;
      m_tvalid_d = 1'b1;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= '0;
      last_q     <= LAST_RST;
      cnt_q      <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      timeout_q  <= timeout_d;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign grant_id = grant_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed latency/timeout/reset cases plus random
// packet mixes scored against a packet-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] s_tdata;
  logic [N-1:0]   s_tvalid, s_tlast, s_tready;
  logic [W-1:0]   m_tdata;
  logic           m_tvalid, m_tready;
  logic [2:0]     grant_id;
  logic           busy, timeout;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned ref_last;
  logic [7:0]  q_data [N][$];
  logic        q_last [N][$];

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ref_last = N - 1;
  endtask

  task automatic add_pkt(input int unsigned r, input int unsigned len,
                         input logic [7:0] base, input bit rnd);
    for (int unsigned i = 0; i < len; i++) begin
      q_data[r].push_back(rnd ? 8'($urandom) : base + 8'(i));
      q_last[r].push_back(i == len - 1);
    end
  endtask

  task automatic drive_heads();
    for (int unsigned i = 0; i < N; i++) begin
      if (q_data[i].size() > 0) begin
        s_tvalid[i]       = 1'b1;
        s_tdata[i*W +: W] = q_data[i][0];
        s_tlast[i]        = q_last[i][0];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
      end
    end
  endtask

  // mode 0: sink always ready; 1: ready 1-in-4; 2: stalled 100 cycles, then ready
  task automatic run_phase(input int unsigned mode);
    logic [7:0]  exp_q[$];
    int unsigned pos[N];
    int unsigned r, cyc;
    bit          more, fin, found, saw_to, done, empty;
    pos    = '{default: 0};
    saw_to = 1'b0;
    done   = 1'b0;
    cyc    = 0;
    r      = 0;
    forever begin
      more = 1'b0;
      for (int unsigned i = 0; i < N; i++) if (pos[i] < q_data[i].size()) more = 1'b1;
      if (!more) break;
      found = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
        if (!found && pos[(ref_last + k) % N] < q_data[(ref_last + k) % N].size()) begin
          r     = (ref_last + k) % N;
          found = 1'b1;
        end
      end
      fin = 1'b0;
      while (!fin) begin
        exp_q.push_back(q_data[r][pos[r]]);
        fin = q_last[r][pos[r]];
        pos[r]++;
      end
      ref_last = r;
    end
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 3) == 0);
        default: m_tready = (cyc > 100);
      endcase
      drive_heads();
      #1;
      if (timeout) saw_to = 1'b1;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("extra_byte", 32'(m_tdata), 32'h100);
        else                   chk("byte", 32'(m_tdata), 32'(exp_q.pop_front()));
      end
      empty = 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
        if (s_tvalid[i] && s_tready[i]) begin
          void'(q_data[i].pop_front());
          void'(q_last[i].pop_front());
        end
        if (q_data[i].size() > 0) empty = 1'b0;
      end
      if (empty && exp_q.size() == 0) done = 1'b1;
    end
    chk("phase_done", 32'(exp_q.size()), 0);
    chk("no_timeout", 32'(saw_to), 0);
    @(negedge clk);
    s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    @(negedge clk);
    chk("phase_idle_busy", 32'(busy), 0);
    chk("phase_idle_mvalid", 32'(m_tvalid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
    do_reset();
    chk("rst_mvalid", 32'(m_tvalid), 0);
    chk("rst_mdata", 32'(m_tdata), 0);
    chk("rst_sready", 32'(s_tready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_timeout", 32'(timeout), 0);

    // Two-byte message from requester 0, checking arbitration latency
    s_tdata[7:0] = 8'h41; s_tlast = '0; s_tvalid = 3'b001; m_tready = 1'b1;
    @(negedge clk);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_gid", 32'(grant_id), 0);
    chk("t1_sready", 32'(s_tready), 'b001);
    chk("t1_mvalid_early", 32'(m_tvalid), 0);
    @(negedge clk);
    chk("t1_mvalid", 32'(m_tvalid), 1);
    chk("t1_byte0", 32'(m_tdata), 'h41);
    s_tdata[7:0] = 8'h42; s_tlast = 3'b001;
    @(negedge clk);
    chk("t1_byte1", 32'(m_tdata), 'h42);
    chk("t1_busy_end", 32'(busy), 0);
    s_tvalid = '0; s_tlast = '0;
    @(negedge clk);
    chk("t1_drained", 32'(m_tvalid), 0);
    ref_last = 0;

    // All three requesters with two-byte packets, twice
    do_reset();
    for (int unsigned rep = 0; rep < 2; rep++) begin
      add_pkt(0, 2, 8'hA0, 1'b0);
      add_pkt(1, 2, 8'hB0, 1'b0);
      add_pkt(2, 2, 8'hC0, 1'b0);
    end
    run_phase(0);

    // Long stream with a slow sink
    add_pkt(1, 12, 8'h00, 1'b1);
    run_phase(1);

    // Stall timeout: requester 2 goes silent mid-packet while requester 0 waits
    @(negedge clk);
    s_tvalid = 3'b100; s_tdata[23:16] = 8'h10; s_tlast = '0; m_tready = 1'b1;
    @(negedge clk);
    chk("t4_gid2", 32'(grant_id), 2);
    s_tvalid = 3'b101; s_tdata[7:0] = 8'h55; s_tlast = 3'b001;
    @(negedge clk);
    chk("t4_byte", 32'(m_tdata), 'h10);
    s_tvalid = 3'b001;
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t4_to_delay", 32'(n), 16);
    chk("t4_released", 32'(busy), 0);
    @(negedge clk);
    chk("t4_to_pulse", 32'(timeout), 0);
    chk("t4_regrant", 32'(busy), 1);
    chk("t4_gid0", 32'(grant_id), 0);
    @(negedge clk);
    chk("t4_next_byte", 32'(m_tdata), 'h55);
    chk("t4_next_done", 32'(busy), 0);
    s_tvalid = '0; s_tlast = '0;
    ref_last = 0;

    // Long back-pressure with valid held must not time out
    add_pkt(1, 4, 8'h60, 1'b0);
    run_phase(2);

    // Reset in the middle of a packet with a byte waiting in the output register
    @(negedge clk);
    s_tvalid = 3'b010; s_tdata[15:8] = 8'h77; s_tlast = '0; m_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_mvalid_pre", 32'(m_tvalid), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_mvalid", 32'(m_tvalid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_mdata", 32'(m_tdata), 0);
    rst = 1'b0; s_tvalid = 3'b111; s_tdata = 24'($urandom); s_tlast = 3'b111;
    @(negedge clk);
    chk("t6_busy_after", 32'(busy), 1);
    chk("t6_gid", 32'(grant_id), 0);
    do_reset();

    // Random packet mixes
    for (int unsigned p = 0; p < 12; p++) begin
      for (int unsigned r = 0; r < N; r++) begin
        n = $urandom_range(0, 2);
        for (int unsigned k = 0; k < n; k++) add_pkt(r, $urandom_range(1, 5), 8'h00, 1'b1);
      end
      run_phase($urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
